seg7_scan_controller: RTL and testbench
=======================================

Name: seg7_scan_controller

Overview:
Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one BCD-to-7-segment decoder. It holds a frame of BCD digits in a shadow register and steps through the digit positions in turn. For each position it presents that digit's BCD value to the shared decoder and enables the matching anode, with a blanking gap between digits to suppress ghosting. New frame data is accepted through a load handshake and applied only at frame boundaries, so the display never tears.

Parameters:
NUM_DIGITS, 4, number of multiplexed digit positions (2..8)
DIGIT_CYCLES, 50000, clk cycles per digit slot (blank phase plus on phase)
BLANK_CYCLES, 500, clk cycles at the start of each slot with all anodes off; 1 <= BLANK_CYCLES < DIGIT_CYCLES

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (reset=0 resets the block)
en  in  1  scan enable; 0 freezes the scan and turns all anodes off
load  in  1  one-cycle strobe; digits_in is captured on this cycle
digits_in  in  4*NUM_DIGITS  new frame data; digit k is bits [4k+3:4k]; digit 0 is the rightmost digit
lz_blank  in  1  1 = suppress leading zeros
bcd_out  out  4  BCD value sent to the shared decoder's bcd_data input
an  out  NUM_DIGITS  anode enables, active-low; an[k]=0 lights digit k
digit_idx  out  clog2(NUM_DIGITS)  index of the current slot
load_ack  out  1  one-cycle pulse when pending data is moved into the shadow register
frame_done  out  1  one-cycle pulse at the start of each new frame

Behaviour:
- All outputs are registered.
- Reset (async, reset=0) sets:
  - an all ones, bcd_out=0, digit_idx=0, load_ack=0, frame_done=0
  - shadow register 0, pending register 0, pending_valid=0
  - state BLANK, slot counter 0
- FSM has two states, BLANK and ON. A slot counter runs from 0 to DIGIT_CYCLES-1.
  - BLANK: an all ones; counter increments; when counter = BLANK_CYCLES-1, go to ON.
  - ON: an[digit_idx]=0 and all other anodes 1, unless the digit is blanked.
  - At counter = DIGIT_CYCLES-1: counter goes to 0, digit_idx goes to (digit_idx+1) mod NUM_DIGITS, state goes to BLANK.
- bcd_out is updated to shadow digit[digit_idx] on the first BLANK cycle of each slot. The decoder therefore settles while all anodes are off.
- Scan order is 0, 1, ..., NUM_DIGITS-1, then wraps to 0.
- Frame boundary is the last cycle of slot NUM_DIGITS-1. On the next cycle (first cycle of slot 0) frame_done=1.
- Load handshake:
  - load=1 writes digits_in into the pending register and sets pending_valid. This happens regardless of en or state.
  - If a load arrives while pending_valid=1, the new data overwrites the pending register; only one ack is produced.
  - At the frame boundary, if pending_valid=1: shadow <= pending, pending_valid cleared, and load_ack=1 in the same cycle as frame_done.
  - If load=1 on the boundary cycle itself, the old pending data transfers to shadow now, the new data is written into pending, and pending_valid stays 1. The new data transfers at the next boundary.
- Leading-zero blanking:
  - Digit k>0 is blanked when lz_blank=1 and shadow digits k..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps its anode at 1 for the whole slot; bcd_out is still driven and the slot timing is unchanged.
- en=0:
  - an forced to all ones on the next clock.
  - Counter, state and digit_idx hold their values.
  - No frame boundary occurs, so no load_ack or frame_done.
  - When en returns to 1, the scan resumes from the held counter value.
- Non-BCD digit values (10..15) pass through unchanged; the decoder shows its default pattern for them.
- Reset asserted mid-frame returns all state immediately; pending data is discarded.

Test Plan:
- Sim params NUM_DIGITS=4, DIGIT_CYCLES=8, BLANK_CYCLES=2. Release reset, en=1, no load -> an=1111 for 2 cycles, then 1110 for 6 cycles, then 1111 for 2 cycles, then 1101; bcd_out=0 throughout; frame_done pulses every 32 cycles.
- load with digits_in=16'h4321 mid-frame -> shadow unchanged until the boundary; load_ack and frame_done pulse together; the next frame gives bcd_out 1,2,3,4 in slots 0..3.
- Two loads (16'h1111, then 16'h9876) within one frame -> a single load_ack; the displayed frame is 9,8,7,6 (MSB to LSB).
- load 16'h0050 with lz_blank=1 -> an[3] and an[2] stay 1 for their whole slots; slots 0 and 1 light normally. With lz_blank=0, all four digits light.
- en=0 for 10 cycles mid-ON -> an=1111 and digit_idx/counter frozen; after en=1, the remaining ON cycles complete before the next slot.
- reset pulsed low mid-slot with a pending load -> outputs take their reset values asynchronously; no load_ack follows; the display shows 0000.

Source files
------------

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller
// Time-multiplexed scan controller for a bank of common-anode 7-segment
// digits sharing one BCD-to-7-segment decoder. A frame of BCD digits is
// held in a shadow register and each digit position gets a slot made of a
// blank phase (all anodes off, decoder settles) followed by an on phase.
// New frames arrive through a pending register and are promoted to the
// shadow only at frame boundaries so the display never tears.
module seg7_scan_controller #(
   parameter int NUM_DIGITS   = 4,
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          en,
   input  logic                          load,
   input  logic [4*NUM_DIGITS-1:0]       digits_in,
   input  logic                          lz_blank,
   output logic [3:0]                    bcd_out,
   output logic [NUM_DIGITS-1:0]         an,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          load_ack,
   output logic                          frame_done
);

   localparam int IDX_W   = $clog2(NUM_DIGITS);
   localparam int CNT_W   = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam int FRAME_W = 4 * NUM_DIGITS;

   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_ON    = 1'b1;

   localparam logic [CNT_W-1:0]      CNT_ZERO       = CNT_W'(0);
   localparam logic [CNT_W-1:0]      CNT_ONE        = CNT_W'(1);
   localparam logic [CNT_W-1:0]      CNT_LAST       = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0]      CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0]      IDX_ZERO       = IDX_W'(0);
   localparam logic [IDX_W-1:0]      IDX_ONE        = IDX_W'(1);
   localparam logic [IDX_W-1:0]      IDX_LAST       = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_OFF         = {NUM_DIGITS{1'b1}};
   localparam logic [FRAME_W-1:0]    FRAME_ZERO     = {FRAME_W{1'b0}};

   // Select one 4-bit digit out of a packed frame.
   function automatic logic [3:0] pick_digit(input logic [FRAME_W-1:0] frame,
                                             input logic [IDX_W-1:0]   idx);
      logic [3:0] d;
      d = 4'h0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == IDX_W'(k)) begin
            d = frame[4*k +: 4];
         end else begin
            d = d;
         end
      end
      return d;
   endfunction

   // Registered state
   logic [0:0]            state_r;
   logic [CNT_W-1:0]      cnt_r;
   logic [IDX_W-1:0]      digit_idx_r;
   logic [FRAME_W-1:0]    shadow_r;
   logic [FRAME_W-1:0]    pending_r;
   logic                  pending_valid_r;
   logic [NUM_DIGITS-1:0] an_r;
   logic [3:0]            bcd_out_r;
   logic                  load_ack_r;
   logic                  frame_done_r;

   // Next-state values
   logic [0:0]            state_nxt_s;
   logic [CNT_W-1:0]      cnt_nxt_s;
   logic [IDX_W-1:0]      idx_nxt_s;
   logic                  slot_end_s;
   logic                  boundary_s;
   logic [FRAME_W-1:0]    shadow_nxt_s;
   logic [FRAME_W-1:0]    pending_nxt_s;
   logic                  pending_valid_nxt_s;
   logic                  load_ack_nxt_s;
   logic [NUM_DIGITS-1:0] lz_mask_s;
   logic                  zero_above_s;
   logic [NUM_DIGITS-1:0] an_nxt_s;
   logic [3:0]            bcd_nxt_s;

   // Slot timing: counter, blank/on phase and digit position advance only while enabled.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      idx_nxt_s   = digit_idx_r;
      slot_end_s  = 1'b0;
      if (en) begin
         if (cnt_r == CNT_LAST) begin
            slot_end_s  = 1'b1;
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = ST_BLANK;
            if (digit_idx_r == IDX_LAST) begin
               idx_nxt_s = IDX_ZERO;
            end else begin
               idx_nxt_s = digit_idx_r + IDX_ONE;
            end
         end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
            case (state_r)
               ST_BLANK: begin
                  if (cnt_r == CNT_BLANK_LAST) begin
                     state_nxt_s = ST_ON;
                  end else begin
                     state_nxt_s = ST_BLANK;
                  end
               end
               ST_ON:   state_nxt_s = ST_ON;
               default: state_nxt_s = ST_BLANK;
            endcase
         end
      end else begin
         state_nxt_s = state_r;
      end
   end

   // The frame boundary is the last cycle of the last digit slot.
   always_comb begin
      if (slot_end_s && (digit_idx_r == IDX_LAST)) begin
         boundary_s = 1'b1;
      end else begin
         boundary_s = 1'b0;
      end
   end

   // Load handshake: pending data is promoted at the boundary before a same-cycle load overwrites it.
   always_comb begin
      shadow_nxt_s        = shadow_r;
      pending_nxt_s       = pending_r;
      pending_valid_nxt_s = pending_valid_r;
      load_ack_nxt_s      = 1'b0;
      if (boundary_s && pending_valid_r) begin
         shadow_nxt_s        = pending_r;
         pending_valid_nxt_s = 1'b0;
         load_ack_nxt_s      = 1'b1;
      end else begin
         load_ack_nxt_s      = 1'b0;
      end
      if (load) begin
         pending_nxt_s       = digits_in;
         pending_valid_nxt_s = 1'b1;
      end else begin
         pending_nxt_s       = pending_nxt_s;
      end
   end

   // Leading-zero mask: digit k>0 is hidden when it and every digit above it are zero.
   always_comb begin
      zero_above_s = 1'b1;
      lz_mask_s    = {NUM_DIGITS{1'b0}};
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         if (shadow_nxt_s[4*k +: 4] != 4'h0) begin
            zero_above_s = 1'b0;
         end else begin
            zero_above_s = zero_above_s;
         end
         if ((k != 0) && lz_blank && zero_above_s) begin
            lz_mask_s[k] = 1'b1;
         end else begin
            lz_mask_s[k] = 1'b0;
         end
      end
   end

   // Anode pattern for the coming cycle, aligned with the next phase and slot.
   always_comb begin
      an_nxt_s = AN_OFF;
      if (en && (state_nxt_s == ST_ON) && !lz_mask_s[idx_nxt_s]) begin
         an_nxt_s[idx_nxt_s] = 1'b0;
      end else begin
         an_nxt_s = AN_OFF;
      end
   end

   // Decoder input changes only as a new slot starts, while all anodes are off.
   always_comb begin
      if (slot_end_s) begin
         bcd_nxt_s = pick_digit(shadow_nxt_s, idx_nxt_s);
      end else begin
         bcd_nxt_s = bcd_out_r;
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r         <= ST_BLANK;
         cnt_r           <= CNT_ZERO;
         digit_idx_r     <= IDX_ZERO;
         shadow_r        <= FRAME_ZERO;
         pending_r       <= FRAME_ZERO;
         pending_valid_r <= 1'b0;
         an_r            <= AN_OFF;
         bcd_out_r       <= 4'h0;
         load_ack_r      <= 1'b0;
         frame_done_r    <= 1'b0;
      end else begin
         state_r         <= state_nxt_s;
         cnt_r           <= cnt_nxt_s;
         digit_idx_r     <= idx_nxt_s;
         shadow_r        <= shadow_nxt_s;
         pending_r       <= pending_nxt_s;
         pending_valid_r <= pending_valid_nxt_s;
         an_r            <= an_nxt_s;
         bcd_out_r       <= bcd_nxt_s;
         load_ack_r      <= load_ack_nxt_s;
         frame_done_r    <= boundary_s;
      end
   end

   assign an         = an_r;
   assign bcd_out    = bcd_out_r;
   assign digit_idx  = digit_idx_r;
   assign load_ack   = load_ack_r;
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Self-checking bench for seg7_scan_controller (4 digits, 8-cycle slots,
// 2-cycle blank). A cycle-level model pushes the expected outputs into a
// scoreboard queue as each stimulus cycle is driven; they are popped and
// compared one time unit after the clock edge. Directed frame-level checks
// cover displayed digits, blanking, ack counts and freeze behaviour.
module tb_seg7_scan_controller;

   localparam int ND = 4;
   localparam int DC = 8;
   localparam int BC = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        load;
   logic [15:0] digits_in;
   logic        lz_blank;
   logic [3:0]  bcd_out;
   logic [3:0]  an;
   logic [1:0]  digit_idx;
   logic        load_ack;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] e_an;
      logic [3:0] e_bcd;
      logic [1:0] e_idx;
      logic       e_ack;
      logic       e_fd;
   } exp_t;

   exp_t sb_q[$];

   // reference model state
   int          m_cnt;
   int          m_idx;
   logic [15:0] m_sh;
   logic [15:0] m_pd;
   logic        m_pv;
   logic [3:0]  m_bcd;

   // observation helpers for frame-level checks
   logic [3:0] obs_bcd [ND];
   logic       obs_lit [ND];
   int         lit_cyc [ND];
   int         ack_cnt;
   int         fd_cnt;

   seg7_scan_controller #(
      .NUM_DIGITS  (ND),
      .DIGIT_CYCLES(DC),
      .BLANK_CYCLES(BC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .load      (load),
      .digits_in (digits_in),
      .lz_blank  (lz_blank),
      .bcd_out   (bcd_out),
      .an        (an),
      .digit_idx (digit_idx),
      .load_ack  (load_ack),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_idx = 0;
      m_sh  = 16'h0000;
      m_pd  = 16'h0000;
      m_pv  = 1'b0;
      m_bcd = 4'h0;
   endtask

   function automatic logic hidden(input int idx);
      return lz_blank && (idx > 0) && ((m_sh >> (4 * idx)) == 16'h0000);
   endfunction

   // Advance the model across one clock edge using the inputs now driven.
   task automatic model_edge();
      exp_t e;
      e.e_ack = 1'b0;
      e.e_fd  = 1'b0;
      if (en) begin
         if ((m_cnt == DC - 1) && (m_idx == ND - 1)) begin
            e.e_fd = 1'b1;
            if (m_pv) begin
               m_sh    = m_pd;
               m_pv    = 1'b0;
               e.e_ack = 1'b1;
            end
         end
         if (m_cnt == DC - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % ND;
            m_bcd = m_sh[4*m_idx +: 4];
         end else begin
            m_cnt = m_cnt + 1;
         end
      end
      if (load) begin
         m_pd = digits_in;
         m_pv = 1'b1;
      end
      e.e_an = 4'hF;
      if (en && (m_cnt >= BC) && !hidden(m_idx)) e.e_an[m_idx] = 1'b0;
      e.e_bcd = m_bcd;
      e.e_idx = 2'(m_idx);
      sb_q.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      chk("sb_depth", sb_q.size(), 1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk("an", an, e.e_an);
         chk("bcd_out", bcd_out, e.e_bcd);
         chk("digit_idx", digit_idx, e.e_idx);
         chk("load_ack", load_ack, e.e_ack);
         chk("frame_done", frame_done, e.e_fd);
      end
      if (load_ack === 1'b1) ack_cnt++;
      if (frame_done === 1'b1) fd_cnt++;
      if (an !== 4'hF) begin
         obs_lit[digit_idx] = 1'b1;
         lit_cyc[digit_idx]++;
      end
      if (en && (m_cnt == BC)) obs_bcd[digit_idx] = bcd_out;
   endtask

   task automatic cycle(input logic c_en, input logic c_ld, input logic [15:0] c_d, input logic c_lz);
      en        = c_en;
      load      = c_ld;
      digits_in = c_d;
      lz_blank  = c_lz;
      model_edge();
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic run(input int n, input logic r_en, input logic r_lz);
      for (int i = 0; i < n; i++) cycle(r_en, 1'b0, 16'h0000, r_lz);
   endtask

   task automatic clear_obs();
      for (int i = 0; i < ND; i++) begin
         obs_bcd[i] = 4'hX;
         obs_lit[i] = 1'b0;
         lit_cyc[i] = 0;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_an"}, an, 4'hF);
      chk({tag, "_bcd"}, bcd_out, 4'h0);
      chk({tag, "_idx"}, digit_idx, 2'd0);
      chk({tag, "_ack"}, load_ack, 1'b0);
      chk({tag, "_fd"}, frame_done, 1'b0);
   endtask

   initial begin
      logic [1:0] idx_hold;
      reset = 1'b0; en = 1'b0; load = 1'b0; digits_in = 16'h0000; lz_blank = 1'b0;
      model_reset();
      clear_obs();
      ack_cnt = 0;
      fd_cnt  = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      reset = 1'b1;

      // Free-running scan of an all-zero frame: two frames, two frame_done pulses.
      run(64, 1'b1, 1'b0);
      chk("fd_count_2frames", fd_cnt, 2);

      // Mid-frame load of 4321: applied at the boundary, then shown as 1,2,3,4.
      ack_cnt = 0;
      run(10, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 16'h4321, 1'b0);
      run(21, 1'b1, 1'b0);
      chk("ack_4321", ack_cnt, 1);
      clear_obs();
      run(32, 1'b1, 1'b0);
      chk("d0_4321", obs_bcd[0], 4'h1);
      chk("d1_4321", obs_bcd[1], 4'h2);
      chk("d2_4321", obs_bcd[2], 4'h3);
      chk("d3_4321", obs_bcd[3], 4'h4);

      // Two loads in one frame: the second wins and only one ack is produced.
      ack_cnt = 0;
      run(5, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 16'h1111, 1'b0);
      run(5, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 16'h9876, 1'b0);
      run(20, 1'b1, 1'b0);
      clear_obs();
      run(32, 1'b1, 1'b0);
      chk("ack_double", ack_cnt, 1);
      chk("d0_9876", obs_bcd[0], 4'h6);
      chk("d1_9876", obs_bcd[1], 4'h7);
      chk("d2_9876", obs_bcd[2], 4'h8);
      chk("d3_9876", obs_bcd[3], 4'h9);

      // Leading-zero blanking of 0050, then the same frame without blanking.
      cycle(1'b1, 1'b1, 16'h0050, 1'b1);
      run(31, 1'b1, 1'b1);
      clear_obs();
      run(32, 1'b1, 1'b1);
      chk("lz_lit0", obs_lit[0], 1'b1);
      chk("lz_lit1", obs_lit[1], 1'b1);
      chk("lz_lit2", obs_lit[2], 1'b0);
      chk("lz_lit3", obs_lit[3], 1'b0);
      clear_obs();
      run(32, 1'b1, 1'b0);
      chk("nolz_lit2", obs_lit[2], 1'b1);
      chk("nolz_lit3", obs_lit[3], 1'b1);
      chk("nolz_bcd3", obs_bcd[3], 4'h0);

      // Freeze for 10 cycles mid-ON in slot 0; the remaining ON cycles still complete.
      clear_obs();
      run(4, 1'b1, 1'b0);
      idx_hold = digit_idx;
      run(10, 1'b0, 1'b0);
      chk("freeze_idx", digit_idx, idx_hold);
      chk("freeze_an", an, 4'hF);
      run(28, 1'b1, 1'b0);
      chk("freeze_on_cycles", lit_cyc[0], 6);
      chk("freeze_slot1_cycles", lit_cyc[1], 6);

      // Load on the boundary cycle itself: old pending shows first, new one a frame later.
      ack_cnt = 0;
      run(10, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 16'h5555, 1'b0);
      run(20, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 16'h0777, 1'b0);
      clear_obs();
      run(32, 1'b1, 1'b0);
      chk("bnd_d0_5", obs_bcd[0], 4'h5);
      chk("bnd_d3_5", obs_bcd[3], 4'h5);
      clear_obs();
      run(32, 1'b1, 1'b0);
      chk("bnd_d0_7", obs_bcd[0], 4'h7);
      chk("bnd_d3_0", obs_bcd[3], 4'h0);
      chk("bnd_ack_count", ack_cnt, 2);

      // Reset mid-slot with a load pending: async reset values, no ack, display 0000.
      cycle(1'b1, 1'b1, 16'h1234, 1'b0);
      run(3, 1'b1, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      chk_reset_vals("midrst");
      model_reset();
      sb_q.delete();
      #2;
      reset = 1'b1;
      ack_cnt = 0;
      clear_obs();
      run(32, 1'b1, 1'b0);
      clear_obs();
      run(32, 1'b1, 1'b0);
      chk("midrst_ack", ack_cnt, 0);
      chk("midrst_d0", obs_bcd[0], 4'h0);
      chk("midrst_d1", obs_bcd[1], 4'h0);
      chk("midrst_d2", obs_bcd[2], 4'h0);
      chk("midrst_d3", obs_bcd[3], 4'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
